// File: rtl/gf128_pkg.sv
// Shared GF(2^128) constants, FSM state type and golden model.
// Bit order is GCM: bit 127 holds the x^0 coefficient.
package gf128_pkg;

  localparam int GF_W = 128;
  localparam logic [GF_W-1:0] GF_R =
    128'he1000000_00000000_00000000_00000000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  // Bit-serial reference multiply, MSB-first over x.
  function automatic logic [GF_W-1:0] gf128_mul_ref(
    input logic [GF_W-1:0] x,
    input logic [GF_W-1:0] h
  );
    logic [GF_W-1:0] z;
    logic [GF_W-1:0] v;
    z = '0;
    v = h;
    for (int i = 0; i < GF_W; i++) begin
      if (x[GF_W-1-i]) z = z ^ v;
      v = v[0] ? ((v >> 1) ^ GF_R) : (v >> 1);
    end
    return z;
  endfunction

endpackage

// File: rtl/gf128_mul_ds_if.sv
// Operand/result handshake bundle for the GF(2^128) multiplier.
// master: operand producer + result consumer; slave: multiplier.
interface gf128_mul_ds_if;

  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_x;
  logic [127:0] in_h;
  logic         in_acc;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_z;

  modport master (
    output in_valid, in_x, in_h, in_acc, out_ready,
    input  in_ready, out_valid, out_z
  );

  modport slave (
    input  in_valid, in_x, in_h, in_acc, out_ready,
    output in_ready, out_valid, out_z
  );

endinterface

// File: rtl/gf128_digit_step.sv
// Combinational DIGIT_W-bit slice of the shift-and-add GF multiply.
// Ports: z_in/v_in state in, x_slice (MSB first), z_out/v_out state out.
module gf128_digit_step
  import gf128_pkg::*;
#(
  parameter int DIGIT_W = 8
) (
  input  logic [GF_W-1:0]    z_in,
  input  logic [GF_W-1:0]    v_in,
  input  logic [DIGIT_W-1:0] x_slice,
  output logic [GF_W-1:0]    z_out,
  output logic [GF_W-1:0]    v_out
);

  logic [GF_W-1:0] zc [DIGIT_W+1];
  logic [GF_W-1:0] vc [DIGIT_W+1];

  assign zc[0] = z_in;
  assign vc[0] = v_in;

  for (genvar i = 0; i < DIGIT_W; i++) begin : g_bit
    assign zc[i+1] = x_slice[DIGIT_W-1-i] ?
                     (zc[i] ^ vc[i]) : zc[i];
    // Multiply V by x, folding the x^128 term back in.
    assign vc[i+1] = vc[i][0] ?
                     ((vc[i] >> 1) ^ GF_R) : (vc[i] >> 1);
  end

  assign z_out = zc[DIGIT_W];
  assign v_out = vc[DIGIT_W];

endmodule

// File: rtl/gf128_mul_ds.sv
// Digit-serial GF(2^128) multiplier, Z = (X ^ ACC) * H mod P.
// Ports: clk, rst (async high), bus (slave side of gf128_mul_ds_if).
module gf128_mul_ds
  import gf128_pkg::*;
#(
  parameter int DIGIT_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  gf128_mul_ds_if.slave  bus
);

  localparam int ITER = GF_W / DIGIT_W;
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

  if (GF_W % DIGIT_W != 0) begin : g_bad_digit
    $error("DIGIT_W must divide 128");
  end

  state_t          state;
  state_t          state_nx;
  logic [GF_W-1:0] xw;
  logic [GF_W-1:0] z;
  logic [GF_W-1:0] v;
  logic [GF_W-1:0] acc;
  logic [GF_W-1:0] z_nx;
  logic [GF_W-1:0] v_nx;
  logic [CW-1:0]   cnt;
  logic            last;
  logic            in_ready;
  logic            out_valid;

  assign last = (cnt == CW'(ITER - 1));

  // Next digit of X is always the top slice; xw shifts left.
  gf128_digit_step #(
    .DIGIT_W (DIGIT_W)
  ) u_step (
    .z_in    (z),
    .v_in    (v),
    .x_slice (xw[GF_W-1 -: DIGIT_W]),
    .z_out   (z_nx),
    .v_out   (v_nx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_nx = S_BUSY;
      end
      S_BUSY: begin
        if (last) state_nx = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xw  <= '0;
      z   <= '0;
      v   <= '0;
      acc <= '0;
      cnt <= '0;
    end else begin
      if (in_ready && bus.in_valid) begin
        xw  <= bus.in_x ^ (bus.in_acc ? acc : '0);
        v   <= bus.in_h;
        z   <= '0;
        cnt <= '0;
      end else if (state == S_BUSY) begin
        xw  <= xw << DIGIT_W;
        z   <= z_nx;
        v   <= v_nx;
        cnt <= cnt + 1'b1;
      end
      if (out_valid && bus.out_ready) acc <= z;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_z     = out_valid ? z : '0;

endmodule

// File: tb/tb_gf128_mul_ds.sv
// Directed and swept checks of the digit-serial GF(2^128) multiplier.
// DIGIT_W=8 instance for protocol tests; 1/32/128 for the sweep.
module tb_gf128_mul_ds;
  import gf128_pkg::*;

  localparam logic [127:0] H1  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] ONE = 128'h80000000_00000000_00000000_00000000;
  localparam logic [127:0] C2  = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [127:0] Z2  = 128'h5e2ec746917062882c85b0685353deb7;
  localparam logic [127:0] XX  = 128'h40000000_00000000_00000000_00000000;
  localparam logic [127:0] RR  = 128'he1000000_00000000_00000000_00000000;
  localparam logic [127:0] X4  = 128'h0123456789abcdeffedcba9876543210;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  gf128_mul_ds_if b8 ();
  gf128_mul_ds_if b1 ();
  gf128_mul_ds_if b32 ();
  gf128_mul_ds_if b128 ();

  gf128_mul_ds #(.DIGIT_W(8))   u8   (.clk(clk), .rst(rst), .bus(b8));
  gf128_mul_ds #(.DIGIT_W(1))   u1   (.clk(clk), .rst(rst), .bus(b1));
  gf128_mul_ds #(.DIGIT_W(32))  u32  (.clk(clk), .rst(rst), .bus(b32));
  gf128_mul_ds #(.DIGIT_W(128)) u128 (.clk(clk), .rst(rst), .bus(b128));

  logic         sw_valid = 1'b0;
  logic [127:0] sw_x = '0;
  logic [127:0] sw_h = '0;

  assign b1.in_valid   = sw_valid;
  assign b1.in_x       = sw_x;
  assign b1.in_h       = sw_h;
  assign b1.in_acc     = 1'b0;
  assign b1.out_ready  = 1'b1;
  assign b32.in_valid  = sw_valid;
  assign b32.in_x      = sw_x;
  assign b32.in_h      = sw_h;
  assign b32.in_acc    = 1'b0;
  assign b32.out_ready = 1'b1;
  assign b128.in_valid  = sw_valid;
  assign b128.in_x      = sw_x;
  assign b128.in_h      = sw_h;
  assign b128.in_acc    = 1'b0;
  assign b128.out_ready = 1'b1;

  logic [2:0]   sw_ov;
  logic [127:0] sw_z [3];
  assign sw_ov   = {b128.out_valid, b32.out_valid, b1.out_valid};
  assign sw_z[0] = b1.out_z;
  assign sw_z[1] = b32.out_z;
  assign sw_z[2] = b128.out_z;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Entered at a negedge; returns at the negedge where out_valid is seen.
  task automatic send(input logic [127:0] x,
                      input logic [127:0] h,
                      input logic acc,
                      output int lat);
    int w;
    w = 0;
    while (!b8.in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    b8.in_valid = 1'b1;
    b8.in_x     = x;
    b8.in_h     = h;
    b8.in_acc   = acc;
    @(negedge clk);
    b8.in_valid = 1'b0;
    b8.in_x     = ~x;
    chk("busy_rdy", {127'd0, b8.in_ready}, 128'd0);
    lat = 0;
    while (!b8.out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic take(input string tag, input logic [127:0] exp);
    chk(tag, b8.out_z, exp);
    chk({tag, "_v"}, {127'd0, b8.out_valid}, 128'd1);
    b8.out_ready = 1'b1;
    @(negedge clk);
    b8.out_ready = 1'b0;
    chk({tag, "_rdy"}, {127'd0, b8.in_ready}, 128'd1);
  endtask

  initial begin
    int lat;
    int sl [3];
    logic [127:0] sz [3];
    logic [127:0] x;
    logic [127:0] h;
    logic [127:0] e;
    logic [127:0] p4;
    int exp_lat [3];
    exp_lat = '{128, 4, 1};

    b8.in_valid  = 1'b0;
    b8.in_x      = '0;
    b8.in_h      = '0;
    b8.in_acc    = 1'b0;
    b8.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rdy", {127'd0, b8.in_ready}, 128'd1);
    chk("rst_ov", {127'd0, b8.out_valid}, 128'd0);
    chk("rst_z", b8.out_z, 128'd0);
    rst = 1'b0;
    @(negedge clk);

    send(ONE, H1, 1'b0, lat);
    chk("t1_lat", lat, 16);
    take("t1", H1);

    send(C2, H1, 1'b0, lat);
    chk("t2_lat", lat, 16);
    take("t2", Z2);

    send('0, H1, 1'b1, lat);
    take("t3", gf128_mul_ref(Z2, H1));

    send(XX, 128'd1, 1'b0, lat);
    take("hand", RR);

    p4 = gf128_mul_ref(X4, H1);
    send(X4, H1, 1'b0, lat);
    for (int i = 0; i < 20; i++) begin
      chk("bp_z", b8.out_z, p4);
      chk("bp_st", {126'd0, b8.out_valid, b8.in_ready}, 128'd2);
      b8.in_valid = i[0];
      b8.in_x     = ~X4;
      b8.in_acc   = 1'b1;
      @(negedge clk);
    end
    b8.in_valid = 1'b0;
    take("bp", p4);
    send('0, H1, 1'b1, lat);
    take("bp_acc", gf128_mul_ref(p4, H1));

    b8.in_valid = 1'b1;
    b8.in_x     = H1;
    b8.in_h     = H1;
    b8.in_acc   = 1'b0;
    @(negedge clk);
    b8.in_valid = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_ov", {127'd0, b8.out_valid}, 128'd0);
    chk("mid_z", b8.out_z, 128'd0);
    chk("mid_rdy", {127'd0, b8.in_ready}, 128'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(C2, H1, 1'b1, lat);
    chk("t5_lat", lat, 16);
    take("t5", Z2);

    for (int n = 0; n < 4; n++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      h = {$urandom, $urandom, $urandom, $urandom};
      send(x, h, 1'b0, lat);
      chk("r8_lat", lat, 16);
      take("r8", gf128_mul_ref(x, h));
    end

    for (int n = 0; n < 200; n++) begin
      sw_x = (n == 0) ? '0 : {$urandom, $urandom, $urandom, $urandom};
      sw_h = (n == 1) ? '0 : {$urandom, $urandom, $urandom, $urandom};
      e = gf128_mul_ref(sw_x, sw_h);
      sw_valid = 1'b1;
      @(negedge clk);
      sw_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
        sl[k] = 0;
        sz[k] = '0;
      end
      for (int t = 1; t <= 140; t++) begin
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
          if (sw_ov[k] && sl[k] == 0) begin
            sl[k] = t;
            sz[k] = sw_z[k];
          end
        end
      end
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("sw%0d_z", k), sz[k], e);
        chk($sformatf("sw%0d_lat", k), sl[k], exp_lat[k]);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
